// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore datapath selects, gated enables, ALU decode, retired-instruction counter.
// Latency: outputs combinational from state/inputs; one state per cycle. Backpressure: MemReady stalls FETCH/MEMREAD/MEMWRITE.
// Optional JALR support enabled by defining RV_JALR_EN.
module multicycle_controller #(
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              MemReady,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              Illegal,
    output logic [CNT_W-1:0]  InstRet
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;
`ifdef RV_JALR_EN
    localparam logic [3:0] JALRADR  = 4'd11;
`endif

    logic [3:0] state, next;
    logic [1:0] aluop;
    logic [2:0] aluc3;
    logic       illegal_dec;
    logic       retire;

    always_comb begin
        next        = state;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        aluop       = 2'b00;
        illegal_dec = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: next = MEMADR;
                    7'b0110011:             next = EXECR;
                    7'b0010011:             next = EXECI;
                    7'b1100011:             next = BEQ;
                    7'b1101111:             next = JAL;
`ifdef RV_JALR_EN
                    7'b1100111:             next = JALRADR;
`endif
                    default: begin
                        next        = FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) next = FETCH;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
                next    = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
                next    = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                PCWrite = Zero;
                next    = FETCH;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                next    = ALUWB;
            end
`ifdef RV_JALR_EN
            JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next    = JAL;
            end
`endif
            default: next = FETCH;
        endcase
        Illegal = illegal_dec;
        // Reset must suppress every architectural side effect in the same cycle.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 2'b01;
            7'b1100011: ImmSrc = 2'b10;
            7'b1101111: ImmSrc = 2'b11;
            default:    ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        aluc3 = 3'b000;
        case (aluop)
            2'b00: aluc3 = 3'b000;
            2'b01: aluc3 = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  aluc3 = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  aluc3 = 3'b101;
                    3'b110:  aluc3 = 3'b011;
                    3'b111:  aluc3 = 3'b010;
                    default: aluc3 = 3'b000;
                endcase
            end
        endcase
    end

    assign ALUControl = ALUC_W'(aluc3);

    // The only DECODE->FETCH path is an illegal opcode, which does not retire.
    assign retire = (next == FETCH) && (state != FETCH) && !illegal_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            InstRet <= '0;
        end else begin
            state <= next;
            if (retire) InstRet <= InstRet + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected outputs per cycle queued at drive time, checked at negedge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] InstRet;

    multicycle_controller #(.ALUC_W(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .InstRet(InstRet)
    );

    always #5 clk = ~clk;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                   S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9,
                   S_JAL = 10, S_JALRADR = 11;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                           BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;

    int         compared = 0;
    int         mismatched = 0;
    logic [3:0] exp_ret;
    logic [16:0] exp_q[$];
    logic [3:0]  ret_q[$];

    function automatic logic [16:0] model(int st, logic [6:0] o, logic [2:0] f3, logic f7,
                                          logic z, logic mr, logic rst);
        logic pcw, adr, mw, irw, rw, ill, jalr_ok;
        logic [1:0] rs, sa, sb, imm, aop;
        logic [2:0] ac;
        {pcw, adr, mw, irw, rw, ill} = 6'b0;
        {rs, sa, sb, aop} = 8'b0;
`ifdef RV_JALR_EN
        jalr_ok = 1'b1;
`else
        jalr_ok = 1'b0;
`endif
        case (st)
            S_FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            S_DECODE:   begin
                sa = 2'b01; sb = 2'b01;
                ill = !(o == LW || o == SW || o == RT || o == IT || o == BR || o == JL ||
                        (jalr_ok && o == JR));
            end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            S_MEMREAD:  adr = 1'b1;
            S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            S_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            S_ALUWB:    rw = 1'b1;
            S_BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = z; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            S_JALRADR:  begin sa = 2'b10; sb = 2'b01; end
            default:    ;
        endcase
        case (o)
            SW:      imm = 2'b01;
            BR:      imm = 2'b10;
            JL:      imm = 2'b11;
            default: imm = 2'b00;
        endcase
        if (aop == 2'b00)      ac = 3'b000;
        else if (aop == 2'b01) ac = 3'b001;
        else begin
            case (f3)
                3'b000:  ac = (o[5] && f7) ? 3'b001 : 3'b000;
                3'b010:  ac = 3'b101;
                3'b110:  ac = 3'b011;
                3'b111:  ac = 3'b010;
                default: ac = 3'b000;
            endcase
        end
        if (rst) {pcw, irw, mw, rw, ill} = 5'b0;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac, ill};
    endfunction

    // One clock: drive, queue expectation, compare at negedge, advance past the edge.
    task automatic cyc(input string tag, input int st, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr, input logic rst,
                       input logic ret);
        logic [16:0] gotv, ev;
        logic [3:0]  er;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; MemReady = mr; reset = rst;
        exp_q.push_back(model(st, o, f3, f7, z, mr, rst));
        ret_q.push_back(exp_ret);
        @(negedge clk);
        gotv = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, Illegal};
        ev = exp_q.pop_front();
        er = ret_q.pop_front();
        compared++;
        assert (gotv === ev) else begin
            mismatched++;
            $error("FAIL %s outputs: observed %05h expected %05h", tag, gotv, ev);
        end
        compared++;
        assert (InstRet === er) else begin
            mismatched++;
            $error("FAIL %s InstRet: observed %0d expected %0d", tag, InstRet, er);
        end
        @(posedge clk);
        #1;
        if (rst) exp_ret = 4'd0;
        else if (ret) exp_ret = exp_ret + 4'd1;
    endtask

    task automatic run_r(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7);
        cyc({tag, "_fetch"}, S_FETCH, o, f3, f7, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc({tag, "_decode"}, S_DECODE, o, f3, f7, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc({tag, "_exec"}, (o == RT) ? S_EXECR : S_EXECI, o, f3, f7, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc({tag, "_aluwb"}, S_ALUWB, o, f3, f7, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
        exp_ret = 4'd0;
        @(posedge clk);
        #1;
        // Reset held with MemReady high: enables stay low.
        cyc("rst", S_FETCH, RT, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        run_r("sub", RT, 3'b000, 1'b1);
        run_r("slt", RT, 3'b010, 1'b0);
        run_r("ori", IT, 3'b110, 1'b1);
        run_r("and", RT, 3'b111, 1'b0);
        run_r("addi7", IT, 3'b000, 1'b1);

        // lw with fetch stall and three-cycle memory stall.
        cyc("lw_fstall", S_FETCH, LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_fetch", S_FETCH, LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lw_decode", S_DECODE, LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lw_memadr", S_MEMADR, LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("lw_wait", S_MEMREAD, LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lw_read", S_MEMREAD, LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("lw_wb", S_MEMWB, LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // sw with two-cycle memory stall.
        cyc("sw_fetch", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("sw_decode", S_DECODE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw_memadr", S_MEMADR, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("sw_wait0", S_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw_wait1", S_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("sw_done", S_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // beq taken and not taken.
        cyc("beq1_fetch", S_FETCH, BR, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("beq1_decode", S_DECODE, BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("beq1_taken", S_BEQ, BR, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("beq0_fetch", S_FETCH, BR, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("beq0_decode", S_DECODE, BR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("beq0_nottaken", S_BEQ, BR, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // jal.
        cyc("jal_fetch", S_FETCH, JL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("jal_decode", S_DECODE, JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jal_jal", S_JAL, JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jal_aluwb", S_ALUWB, JL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Unsupported opcode: one-cycle Illegal pulse, no retirement.
        cyc("ill_fetch", S_FETCH, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ill_decode", S_DECODE, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("ill_after", S_FETCH, 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // jalr: supported only when the feature macro is defined.
        cyc("jalr_fetch", S_FETCH, JR, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef RV_JALR_EN
        cyc("jalr_decode", S_DECODE, JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jalr_adr", S_JALRADR, JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jalr_jal", S_JAL, JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jalr_aluwb", S_ALUWB, JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        cyc("jalr_decode", S_DECODE, JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("jalr_after", S_FETCH, JR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Sixteen retirements guarantee the 4-bit counter wraps 15 -> 0.
        for (int i = 0; i < 16; i++)
            run_r("wrap", RT, 3'b000, 1'b0);

        // Reset arriving in MEMWRITE while MemReady is high.
        cyc("swr_fetch", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("swr_decode", S_DECODE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("swr_memadr", S_MEMADR, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("swr_wait", S_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("swr_reset", S_MEMWRITE, SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("swr_after", S_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_r("post_rst", RT, 3'b000, 1'b1);
        cyc("final", S_FETCH, RT, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
